// File: rtl/div_controller.sv
// Multi-cycle DIV/DIVU unit for the EX stage: 32-step restoring divider
// with divide-by-zero short cut, annul abort and pipeline stall request.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           divide request, held while the instruction sits in EX
//   signed_div      1 = DIV (signed), 0 = DIVU
//   opdata1/2       dividend / divisor, sampled when the operation starts
//   annul           flush/exception cancel
//   result          {remainder, quotient}, non-zero only while ready
//   ready           result valid (HI/LO write enable)
//   stall_req       stall request to the hazard unit
module div_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic        stall_req
);

    typedef enum logic [1:0] {
        IDLE,
        DIVZERO,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [5:0]  cnt;
    logic        sd_r;
    logic        sign1;
    logic        sign2;
    logic [31:0] divisor;
    logic [64:0] work;
    logic [63:0] result_r;

    logic        go;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [33:0] trial;
    logic [33:0] diff;
    logic [64:0] step_work;
    logic [31:0] q_raw;
    logic [31:0] r_raw;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign go   = start & ~annul;
    assign abs1 = (signed_div & opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
    assign abs2 = (signed_div & opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;

    // work = {partial remainder[64:32], dividend/quotient[31:0]}.
    // trial is the remainder after the left shift; a borrow out of
    // the subtraction means the divisor did not fit (quotient bit 0).
    assign trial     = work[64:31];
    assign diff      = trial - {2'b00, divisor};
    assign step_work = diff[33] ? {work[63:0], 1'b0}
                                : {diff[32:0], work[30:0], 1'b1};

    assign q_raw = step_work[31:0];
    assign r_raw = step_work[63:32];
    assign q_fix = (sd_r & (sign1 ^ sign2)) ? (~q_raw + 32'd1) : q_raw;
    assign r_fix = (sd_r & sign1) ? (~r_raw + 32'd1) : r_raw;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // next-state logic; annul outranks every other transition
    always_comb begin
        next_state = state;
        if (annul && state != IDLE) begin
            next_state = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        next_state = (opdata2 == 32'd0) ? DIVZERO : BUSY;
                    end
                end
                DIVZERO: next_state = DONE;
                BUSY: begin
                    if (cnt == 6'd31) begin
                        next_state = DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 6'd0;
            sd_r     <= 1'b0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            divisor  <= 32'd0;
            work     <= 65'd0;
            result_r <= 64'd0;
        end else if (annul && state != IDLE) begin
            result_r <= 64'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        sd_r     <= signed_div;
                        sign1    <= opdata1[31];
                        sign2    <= opdata2[31];
                        divisor  <= abs2;
                        work     <= {33'd0, abs1};
                        cnt      <= 6'd0;
                        result_r <= 64'd0;
                    end
                end
                DIVZERO: result_r <= 64'd0;
                BUSY: begin
                    work <= step_work;
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        result_r <= {r_fix, q_fix};
                    end
                end
                DONE: result_r <= result_r;
                default: result_r <= 64'd0;
            endcase
        end
    end

    // outputs
    always_comb begin
        ready     = (state == DONE);
        result    = (state == DONE) ? result_r : 64'd0;
        stall_req = ((state == IDLE) & go & ~rst)
                  | (state == DIVZERO)
                  | (state == BUSY);
    end

endmodule

// File: doc/div_controller.md
DIV_CONTROLLER -- requirements
Module: div_controller

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk rises-edge only, rst sampled on clk.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  EX-stage DIV/DIVU request from the decoded instruction; held high while the instruction stays in EX.
REQ-005 signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start.
REQ-006 opdata1  in  32  dividend; sampled with start.
REQ-007 opdata2  in  32  divisor; sampled with start.
REQ-008 annul  in  1  flush/exception cancel; aborts any operation in progress.
REQ-009 result  out  64  {remainder[63:32], quotient[31:0]}, destined for the HI/LO write.
REQ-010 ready  out  1  result valid; qualifies the hilowrite for the divide.
REQ-011 stall_req  out  1  pipeline stall request to the hazard unit.

Function
REQ-012 The FSM SHALL have four states: IDLE, DIVZERO, BUSY, DONE.
REQ-013 IDLE: start & ~annul & opdata2==0 -> DIVZERO; start & ~annul & opdata2!=0 -> BUSY; otherwise stay.
REQ-014 On leaving IDLE, the block SHALL latch signed_div, the operand signs, and the absolute values of opdata1/opdata2 (absolute only when signed_div=1), and clear a 6-bit counter cnt.
REQ-015 BUSY SHALL perform one restoring radix-2 shift/subtract step per cycle on a 65-bit partial-remainder/quotient register, incrementing cnt; after the step with cnt==31 -> DONE.
REQ-016 DIVZERO SHALL last exactly one cycle and -> DONE with result = 64'h0.
REQ-017 On entering DONE from BUSY, for signed_div=1, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL be negated when the dividend is negative; unsigned results pass unchanged.
REQ-018 DONE: ready=1, result held stable; stay while start=1; start=0 -> IDLE.
REQ-019 stall_req SHALL be combinational: 1 when (IDLE & start & ~annul) or state is DIVZERO or BUSY; 0 in DONE and otherwise.
REQ-020 Latency: start in IDLE at cycle 0 -> BUSY cycles 1..32 -> DONE with ready=1 at cycle 33; stall_req high cycles 0..32.
REQ-021 Divide by zero latency: start at cycle 0 -> DIVZERO cycle 1 -> DONE cycle 2.
REQ-022 annul=1 in DIVZERO, BUSY or DONE SHALL force IDLE on the next edge with ready=0 and result=0; annul takes priority over every other transition.
REQ-023 annul=1 in IDLE SHALL suppress a simultaneous start; stall_req stays 0.
REQ-024 result SHALL be 64'h0 and ready 0 in every state other than DONE.
REQ-025 Operand changes on opdata1/opdata2/signed_div after the start cycle SHALL NOT affect the operation in progress.
REQ-026 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000, remainder 0x00000000; no exception is raised.

Reset
REQ-027 rst=1 SHALL force IDLE, cnt=0, and all internal registers to 0 on the next edge, overriding annul and start.
REQ-028 While and immediately after reset: result=64'h0, ready=0, stall_req=0 (unless start is high in IDLE after rst drops).
REQ-029 Reset asserted mid-BUSY SHALL abort the operation; no ready pulse follows.

Verification
REQ-030 DIVU 100/7, start held -> stall_req high 33 cycles, ready at cycle 33, result={32'd2, 32'd14}; start dropped -> IDLE next cycle.
REQ-031 DIV -7/2 -> result={32'hFFFFFFFF, 32'hFFFFFFFD}; DIV 7/-2 -> {32'h00000001, 32'hFFFFFFFD}.
REQ-032 DIV or DIVU by 0 -> ready at cycle 2, result=64'h0, stall_req high cycles 0..1.
REQ-033 annul at BUSY cycle 10 -> IDLE next edge, ready never asserts, stall_req drops; a new start then completes normally.
REQ-034 DIV 0x80000000 / 0xFFFFFFFF -> result={32'h0, 32'h80000000}; DIVU 0xFFFFFFFF/1 -> {32'h0, 32'hFFFFFFFF}.
REQ-035 rst at BUSY cycle 20 -> IDLE, outputs 0; start with annul=1 in IDLE -> no state change.
